// File: rtl/wb_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wb_stage_pkg
//  Description : Shared types and constants for the write-back arbiter stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package wb_stage_pkg;

   // Width of a per-channel write-back source select
   localparam int WB_SEL_W = 2;

   // Default datapath geometry (matches the top-level parameter defaults)
   localparam int WB_XLEN   = 32;
   localparam int WB_REG_AW = 5;

   // Write-back source select; 2'b11 forces a zero result
   typedef enum logic [WB_SEL_W-1:0] {
      WB_ALU  = 2'b00,
      WB_MEM  = 2'b01,
      WB_PC4  = 2'b10,
      WB_ZERO = 2'b11
   } wb_sel_e;

   // One buffered completion: destination register and its final data.
   // The top packs entries as {rd, data} in the same order as this struct.
   typedef struct packed {
      logic [WB_REG_AW-1:0] rd;
      logic [WB_XLEN-1:0]   data;
   } wb_entry_t;

endpackage
`default_nettype wire

// File: rtl/wb_ch_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : wb_ch_fifo
//  Description : Per-channel completion FIFO with registered full/empty flags.
//                Depth need not be a power of two; pointers wrap explicitly.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_ch_fifo #(
   parameter int WIDTH = 37,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int            PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int            CW   = $clog2(DEPTH + 1);
   localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic [CW-1:0]    count_nxt;
   logic             do_push;
   logic             do_pop;

   // Flags guard against overflow/underflow even if the caller misbehaves
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign dout    = mem[rd_ptr];

   // Next occupancy; simultaneous push and pop leaves the count unchanged
   always_comb begin
      count_nxt = count;
      if (do_push && !do_pop) begin
         count_nxt = count + CW'(1);
      end else if (do_pop && !do_push) begin
         count_nxt = count - CW'(1);
      end
   end

   // Pointers, occupancy and registered status flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         if (do_push) begin
            wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + PW'(1);
         end
         if (do_pop) begin
            rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PW'(1);
         end
         count <= count_nxt;
         full  <= (count_nxt == FULL_CNT);
         empty <= (count_nxt == '0);
      end
   end

   // Entry storage; contents are only meaningful while counted as occupied
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

endmodule
`default_nettype wire

// File: rtl/wb_arbiter_stage.sv
`default_nettype none
// ============================================================================
//  Module      : wb_arbiter_stage
//  Description : Multi-channel write-back stage. Muxes each completion at
//                accept time, buffers it per channel, and round-robin
//                arbitrates onto the single register-file write port.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_arbiter_stage
   import wb_stage_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter int NUM_CH     = 3,
   parameter int FIFO_DEPTH = 2,
   parameter int REG_AW     = 5
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_CH-1:0]        ch_valid,
   output logic [NUM_CH-1:0]        ch_ready,
   input  logic [NUM_CH*2-1:0]      ch_wb_sel,
   input  logic [NUM_CH*XLEN-1:0]   ch_opr_res,
   input  logic [NUM_CH*XLEN-1:0]   ch_dmem_rdata,
   input  logic [NUM_CH*XLEN-1:0]   ch_pc_plus4,
   input  logic [NUM_CH*REG_AW-1:0] ch_rd,
   input  logic [NUM_CH-1:0]        ch_rf_en,
   output logic                     rf_we,
   output logic [REG_AW-1:0]        rf_waddr,
   output logic [XLEN-1:0]          rf_wdata,
   output logic                     wb_busy
);

   localparam int EW = REG_AW + XLEN;
   localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic [NUM_CH-1:0] fifo_full;
   logic [NUM_CH-1:0] fifo_empty;
   logic [NUM_CH-1:0] push;
   logic [NUM_CH-1:0] pop;
   logic [EW-1:0]     din  [NUM_CH];
   logic [EW-1:0]     dout [NUM_CH];

   logic [IW-1:0]     rr_ptr;
   logic [IW-1:0]     grant_idx;
   logic [IW-1:0]     cand_idx;
   logic              grant_valid;
   logic [EW-1:0]     grant_entry;

   assign ch_ready = ~fifo_full;

   generate
      for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
         wb_sel_e           sel;
         logic [XLEN-1:0]   data;
         logic [REG_AW-1:0] rd;

         assign sel = wb_sel_e'(ch_wb_sel[2*c +: 2]);
         assign rd  = ch_rd[REG_AW*c +: REG_AW];

         // Select the write-back source so the FIFO only holds the final word
         always_comb begin
            data = '0;
            case (sel)
               WB_ALU:  data = ch_opr_res[XLEN*c +: XLEN];
               WB_MEM:  data = ch_dmem_rdata[XLEN*c +: XLEN];
               WB_PC4:  data = ch_pc_plus4[XLEN*c +: XLEN];
               default: data = '0;
            endcase
         end

         // Completions without a real destination (disabled or x0) are
         // consumed by the handshake but never enqueued
         assign push[c] = ch_valid[c] & ~fifo_full[c] & ch_rf_en[c] & (rd != '0);
         assign din[c]  = {rd, data};

         wb_ch_fifo #(
            .WIDTH (EW),
            .DEPTH (FIFO_DEPTH)
         ) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (push[c]),
            .pop   (pop[c]),
            .din   (din[c]),
            .dout  (dout[c]),
            .full  (fifo_full[c]),
            .empty (fifo_empty[c])
         );
      end
   endgenerate

   // Round-robin search starting one past the last granted channel
   always_comb begin
      grant_valid = 1'b0;
      grant_idx   = rr_ptr;
      cand_idx    = '0;
      pop         = '0;
      for (int k = 1; k <= NUM_CH; k++) begin
         cand_idx = IW'((int'(rr_ptr) + k) % NUM_CH);
         if (!grant_valid && !fifo_empty[cand_idx]) begin
            grant_valid = 1'b1;
            grant_idx   = cand_idx;
         end
      end
      if (grant_valid) begin
         pop[grant_idx] = 1'b1;
      end
   end

   assign grant_entry = dout[grant_idx];

   // Output register and priority pointer; address/data hold when idle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rf_we    <= 1'b0;
         rf_waddr <= '0;
         rf_wdata <= '0;
         rr_ptr   <= IW'(NUM_CH - 1);
      end else begin
         rf_we <= grant_valid;
         if (grant_valid) begin
            rf_waddr <= grant_entry[EW-1:XLEN];
            rf_wdata <= grant_entry[XLEN-1:0];
            rr_ptr   <= grant_idx;
         end
      end
   end

   assign wb_busy = (~&fifo_empty) | rf_we;

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wb_arbiter_stage
//  Description : Directed self-checking bench for wb_arbiter_stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_arbiter_stage;

   localparam int XLEN = 32;
   localparam int NCH  = 3;
   localparam int AW   = 5;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [NCH-1:0]  ch_valid;
   logic [NCH-1:0]  ch_ready;
   logic [NCH*2-1:0] ch_wb_sel;
   logic [NCH*XLEN-1:0] ch_opr_res;
   logic [NCH*XLEN-1:0] ch_dmem_rdata;
   logic [NCH*XLEN-1:0] ch_pc_plus4;
   logic [NCH*AW-1:0]   ch_rd;
   logic [NCH-1:0]  ch_rf_en;
   logic            rf_we;
   logic [AW-1:0]   rf_waddr;
   logic [XLEN-1:0] rf_wdata;
   logic            wb_busy;

   int checks = 0;
   int errors = 0;
   logic [AW+XLEN-1:0] wr_log [$];

   wb_arbiter_stage #(
      .XLEN(XLEN), .NUM_CH(NCH), .FIFO_DEPTH(2), .REG_AW(AW)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .ch_valid(ch_valid), .ch_ready(ch_ready), .ch_wb_sel(ch_wb_sel),
      .ch_opr_res(ch_opr_res), .ch_dmem_rdata(ch_dmem_rdata),
      .ch_pc_plus4(ch_pc_plus4), .ch_rd(ch_rd), .ch_rf_en(ch_rf_en),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .wb_busy(wb_busy)
   );

   always #5 clk = ~clk;

   // Record every RF write once, mid-cycle
   always @(negedge clk) begin
      if (rst_n && rf_we) wr_log.push_back({rf_waddr, rf_wdata});
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_ch(input int c, input logic v, input logic [1:0] sel,
                         input logic [31:0] opr, input logic [31:0] dmem,
                         input logic [31:0] pc4, input logic [4:0] rd, input logic en);
      ch_valid[c]              = v;
      ch_wb_sel[2*c +: 2]      = sel;
      ch_opr_res[XLEN*c +: XLEN]    = opr;
      ch_dmem_rdata[XLEN*c +: XLEN] = dmem;
      ch_pc_plus4[XLEN*c +: XLEN]   = pc4;
      ch_rd[AW*c +: AW]        = rd;
      ch_rf_en[c]              = en;
   endtask

   // One uncontended completion on channel c, checked through to the RF port
   task automatic single(input string tag, input int c, input logic [1:0] sel,
                         input logic [4:0] rd, input logic [31:0] exp_data);
      set_ch(c, 1'b1, sel, 32'h0000_1234, 32'h0000_DEAD, 32'h0000_0104, rd, 1'b1);
      step();
      ch_valid = '0;
      check({tag, "_we_lat1"}, 64'(rf_we), 64'd0);
      check({tag, "_busy"}, 64'(wb_busy), 64'd1);
      step();
      check({tag, "_we"}, 64'(rf_we), 64'd1);
      check({tag, "_waddr"}, 64'(rf_waddr), 64'(rd));
      check({tag, "_wdata"}, 64'(rf_wdata), 64'(exp_data));
      step();
      check({tag, "_we_done"}, 64'(rf_we), 64'd0);
      check({tag, "_idle"}, 64'(wb_busy), 64'd0);
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      step();
   endtask

   initial begin
      int n0;
      int cyc;
      int seen_not_ready;
      int ch0_cnt;
      logic [AW+XLEN-1:0] ch0_list [$];

      ch_valid = '0; ch_wb_sel = '0; ch_opr_res = '0; ch_dmem_rdata = '0;
      ch_pc_plus4 = '0; ch_rd = '0; ch_rf_en = '0;
      rst_n = 1'b0;

      // 1: reset with valids high
      for (int c = 0; c < NCH; c++) set_ch(c, 1'b1, 2'b00, 32'h55, 32'h0, 32'h0, 5'd1, 1'b1);
      step(); step(); step();
      check("rst_we", 64'(rf_we), 64'd0);
      check("rst_busy", 64'(wb_busy), 64'd0);
      ch_valid = '0;
      rst_n = 1'b1;
      step();
      check("rst_ready", 64'(ch_ready), 64'b111);
      check("rst_waddr", 64'(rf_waddr), 64'd0);
      check("rst_wdata", 64'(rf_wdata), 64'd0);
      check("rst_we_after", 64'(rf_we), 64'd0);

      // 2: single ALU op
      single("alu", 0, 2'b00, 5'd5, 32'h0000_1234);

      // 3: source select on channel 1
      single("sel_mem", 1, 2'b01, 5'd6, 32'h0000_DEAD);
      single("sel_pc4", 1, 2'b10, 5'd8, 32'h0000_0104);
      single("sel_zero", 1, 2'b11, 5'd9, 32'h0000_0000);

      // 4: drops (rd=0, then rf_en=0)
      set_ch(0, 1'b1, 2'b00, 32'h77, 32'h0, 32'h0, 5'd0, 1'b1);
      step();
      ch_valid = '0;
      check("drop_x0_busy", 64'(wb_busy), 64'd0);
      set_ch(0, 1'b1, 2'b00, 32'h78, 32'h0, 32'h0, 5'd7, 1'b0);
      step();
      ch_valid = '0;
      check("drop_en_busy", 64'(wb_busy), 64'd0);
      check("drop_ready", 64'(ch_ready), 64'b111);
      step();
      check("drop_we", 64'(rf_we), 64'd0);
      check("drop_busy", 64'(wb_busy), 64'd0);
      check("drop_hold_addr", 64'(rf_waddr), 64'd9);

      // 5: three-way contention from reset priority, twice
      pulse_reset();
      for (int b = 0; b < 2; b++) begin
         for (int c = 0; c < NCH; c++)
            set_ch(c, 1'b1, 2'b00, 32'hA0 + 32'(16*b) + 32'(c), 32'h0, 32'h0, 5'(c + 1), 1'b1);
         step();
         ch_valid = '0;
         check("rr_lat", 64'(rf_we), 64'd0);
         for (int c = 0; c < NCH; c++) begin
            step();
            check($sformatf("rr_b%0d_we%0d", b, c), 64'(rf_we), 64'd1);
            check($sformatf("rr_b%0d_addr%0d", b, c), 64'(rf_waddr), 64'(c + 1));
            check($sformatf("rr_b%0d_data%0d", b, c), 64'(rf_wdata), 64'(32'hA0 + 32'(16*b) + 32'(c)));
         end
         step();
         check("rr_idle_we", 64'(rf_we), 64'd0);
         check("rr_idle_busy", 64'(wb_busy), 64'd0);
      end

      // 6: backpressure on channel 0 while channels 1/2 stay busy
      pulse_reset();
      wr_log.delete();
      n0 = 0;
      seen_not_ready = 0;
      set_ch(1, 1'b1, 2'b00, 32'hB1, 32'h0, 32'h0, 5'd17, 1'b1);
      set_ch(2, 1'b1, 2'b00, 32'hB2, 32'h0, 32'h0, 5'd18, 1'b1);
      set_ch(0, 1'b1, 2'b00, 32'hC000_0000, 32'h0, 32'h0, 5'd20, 1'b1);
      cyc = 0;
      while (n0 < 4 && cyc < 40) begin
         logic acc;
         acc = ch_ready[0];
         if (!acc) seen_not_ready = 1;
         step();
         cyc++;
         if (acc) begin
            n0++;
            if (n0 < 4)
               set_ch(0, 1'b1, 2'b00, 32'hC000_0000 + 32'(n0), 32'h0, 32'h0, 5'(20 + n0), 1'b1);
            else
               ch_valid[0] = 1'b0;
         end
      end
      check("bp_all_accepted", 64'(n0), 64'd4);
      check("bp_ready_dropped", 64'(seen_not_ready), 64'd1);
      cyc = 0;
      ch0_cnt = 0;
      while (ch0_cnt < 4 && cyc < 40) begin
         step();
         cyc++;
         ch0_cnt = 0;
         foreach (wr_log[i]) if (wr_log[i][AW+XLEN-1:XLEN] >= 5'd20) ch0_cnt++;
      end
      step(); step(); step();
      ch0_list.delete();
      foreach (wr_log[i]) if (wr_log[i][AW+XLEN-1:XLEN] >= 5'd20) ch0_list.push_back(wr_log[i]);
      check("bp_ch0_count", 64'(ch0_list.size()), 64'd4);
      for (int k = 0; k < 4; k++) begin
         logic [AW+XLEN-1:0] e;
         e = (k < ch0_list.size()) ? ch0_list[k] : '0;
         check($sformatf("bp_ch0_entry%0d", k), 64'(e), 64'({5'(20 + k), 32'hC000_0000 + 32'(k)}));
      end

      // Reset while channels 1/2 still have pending writes
      check("bp_busy_before_rst", 64'(wb_busy), 64'd1);
      rst_n = 1'b0;
      #1;
      check("midrst_we", 64'(rf_we), 64'd0);
      check("midrst_busy", 64'(wb_busy), 64'd0);
      check("midrst_ready", 64'(ch_ready), 64'b111);
      ch_valid = '0;
      step();
      rst_n = 1'b1;
      wr_log.delete();
      for (int k = 0; k < 5; k++) step();
      check("midrst_no_writes", 64'(wr_log.size()), 64'd0);
      check("midrst_idle", 64'(wb_busy), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
